// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: status bit layout,
// xbar decode address, FSM state encoding and the baud divisor helper.
package mmio_uart_tx_pkg;

    // Bit positions inside the 32-bit status word
    localparam int STAT_FULL = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_OVF  = 2;

    // Word address of the UART slave port as decoded by mmio_xbar
    localparam logic [29:0] UART_MMIO_WADDR = 30'h0000_0041;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Clock cycles per bit, rounded to nearest
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count. Writes into a full FIFO
// and reads from an empty FIFO are ignored. DEPTH must be a power of two so
// the pointers wrap naturally.
module sync_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: CPU pushes bytes into a small FIFO, an FSM drains
// it as back-to-back 8N1 frames on o_tx. Status word goes to the xbar
// read-data mux.
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_wdata,
    input  logic        i_we,
    input  logic        i_clr_ovf,
    output logic [31:0] o_status,
    output logic        o_tx
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD);
    localparam int BW  = $clog2(DIV);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    uart_state_e   state_q, state_nx;
    logic [BW-1:0] baud_q, baud_nx;
    logic [2:0]    bit_q, bit_nx;
    logic [7:0]    shift_q, shift_nx;
    logic          tx_q, tx_nx;
    logic          ovf_q;
    logic          pop;
    logic          bit_done;
    logic          busy;

    logic [7:0]    fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (i_we),
        .pop   (pop),
        .wdata (i_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_done = (baud_q == BAUD_LAST);
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    assign o_tx     = tx_q;

    // Next-state, baud/bit counters, shifter and next line level
    always_comb begin
        state_nx = state_q;
        baud_nx  = baud_q;
        bit_nx   = bit_q;
        shift_nx = shift_q;
        tx_nx    = tx_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_nx   = 1'b1;
                baud_nx = '0;
                bit_nx  = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_nx = fifo_rdata;
                    state_nx = ST_START;
                    tx_nx    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    baud_nx  = '0;
                    bit_nx   = '0;
                    state_nx = ST_DATA;
                    tx_nx    = shift_q[0];
                end else begin
                    baud_nx = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_nx = '0;
                    bit_nx  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_nx = ST_STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        // Next bit is shift_q[1] once the register shifts right
                        shift_nx = shift_q >> 1;
                        tx_nx    = shift_q[1];
                    end
                end else begin
                    baud_nx = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    baud_nx = '0;
                    // Chain straight into the next frame when data is waiting
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_nx = fifo_rdata;
                        state_nx = ST_START;
                        tx_nx    = 1'b0;
                    end else begin
                        state_nx = ST_IDLE;
                        tx_nx    = 1'b1;
                    end
                end else begin
                    baud_nx = baud_q + BW'(1);
                end
            end
            default: begin
                state_nx = ST_IDLE;
                tx_nx    = 1'b1;
                baud_nx  = '0;
                bit_nx   = '0;
            end
        endcase
    end

    // Control registers; reset aborts any frame and idles the line high
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_nx;
            baud_q  <= baud_nx;
            bit_q   <= bit_nx;
            tx_q    <= tx_nx;
        end
    end

    // Shift register holds payload only; its value is irrelevant outside a frame
    always_ff @(posedge clk) begin
        shift_q <= shift_nx;
    end

    // Sticky overflow: a dropped write wins over a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (i_we && fifo_full) begin
            ovf_q <= 1'b1;
        end else if (i_clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    // Status word assembly for the xbar read mux
    always_comb begin
        o_status            = '0;
        o_status[STAT_FULL] = fifo_full;
        o_status[STAT_BUSY] = busy;
        o_status[STAT_OVF]  = ovf_q;
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at DIV=10, FIFO_DEPTH=4.
module tb_mmio_uart_tx;

    logic        clk;
    logic        rst;
    logic [7:0]  i_wdata;
    logic        i_we;
    logic        i_clr_ovf;
    logic [31:0] o_status;
    logic        o_tx;

    int checks;
    int errors;

    mmio_uart_tx #(
        .CLK_FREQ   (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_wdata   (i_wdata),
        .i_we      (i_we),
        .i_clr_ovf (i_clr_ovf),
        .o_status  (o_status),
        .o_tx      (o_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot n (0=start, 1..8=data LSB first, 9=stop)
    function automatic logic frame_bit(input logic [7:0] b, input int n);
        if (n == 0) return 1'b0;
        if (n == 9) return 1'b1;
        return b[n-1];
    endfunction

    initial begin
        int lows;
        logic [7:0] exp_byte;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        i_we      = 1'b0;
        i_wdata   = 8'h00;
        i_clr_ovf = 1'b0;

        // Test 1: reset for 3 cycles, then 50 idle cycles
        repeat (3) begin
            @(negedge clk);
            check("t1_rst_tx", 32'(o_tx), 32'd1);
            check("t1_rst_status", o_status, 32'd0);
        end
        rst = 1'b0;
        repeat (50) begin
            @(negedge clk);
            check("t1_idle_tx", 32'(o_tx), 32'd1);
            check("t1_idle_status", o_status, 32'd0);
        end

        // Test 2: single byte 0xA5, sample mid-bit at k+6+10n
        i_we    = 1'b1;
        i_wdata = 8'hA5;
        @(negedge clk);
        i_we = 1'b0;
        for (int n = 0; n < 10; n++) begin
            repeat ((n == 0) ? 6 : 10) @(negedge clk);
            check($sformatf("t2_bit%0d", n), 32'(o_tx), 32'(frame_bit(8'hA5, n)));
        end
        repeat (4) @(negedge clk);
        check("t2_busy_k100", o_status, 32'd2);
        @(negedge clk);
        check("t2_idle_k101", o_status, 32'd0);
        check("t2_idle_tx", 32'(o_tx), 32'd1);

        // Test 3: six consecutive pushes, sixth is dropped
        i_we    = 1'b1;
        i_wdata = 8'h01;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            i_wdata = 8'(i);
        end
        @(negedge clk);
        check("t3_full_after5", o_status, 32'd3);
        i_wdata = 8'h06;
        @(negedge clk);
        i_we = 1'b0;
        check("t3_ovf_after6", o_status, 32'd7);
        @(negedge clk);
        for (int j = 0; j < 5; j++) begin
            exp_byte = 8'(j + 1);
            for (int n = 0; n < 10; n++) begin
                check($sformatf("t3_b%0d_bit%0d", j + 1, n), 32'(o_tx), 32'(frame_bit(exp_byte, n)));
                repeat (10) @(negedge clk);
            end
        end
        check("t3_done_status", o_status, 32'd4);
        repeat (30) begin
            check("t3_no_sixth", 32'(o_tx), 32'd1);
            @(negedge clk);
        end

        // Test 4: clear ovf; then dropping write with clear in the same cycle
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_clr_ovf = 1'b0;
        check("t4_clr", o_status, 32'd0);
        i_we    = 1'b1;
        i_wdata = 8'h11;
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            i_wdata = 8'(8'h10 + i);
        end
        @(negedge clk);
        check("t4_full", o_status, 32'd3);
        i_wdata   = 8'h16;
        i_clr_ovf = 1'b1;
        @(negedge clk);
        i_we      = 1'b0;
        check("t4_set_wins", o_status, 32'd7);
        @(negedge clk);
        i_clr_ovf = 1'b0;
        check("t4_clr_again", o_status, 32'd3);

        // Test 5: reset 35 cycles into the 0x11 frame
        repeat (29) @(negedge clk);
        check("t5_pre_rst_tx", 32'(o_tx), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_tx", 32'(o_tx), 32'd1);
        check("t5_rst_status", o_status, 32'd0);
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (o_tx !== 1'b1) lows++;
        end
        check("t5_no_restart", 32'(lows), 32'd0);
        check("t5_status_after", o_status, 32'd0);

        // Test 6: 0x00 then 0xFF; per-cycle line shape
        i_we    = 1'b1;
        i_wdata = 8'h00;
        @(negedge clk);
        i_wdata = 8'hFF;
        @(negedge clk);
        i_we = 1'b0;
        lows = 0;
        for (int m = 1; m <= 220; m++) begin
            check($sformatf("t6_m%0d", m), 32'(o_tx),
                  ((m <= 90) || (m >= 101 && m <= 110)) ? 32'd0 : 32'd1);
            if (m <= 100 && o_tx === 1'b0) lows++;
            @(negedge clk);
        end
        check("t6_zero_low_len", 32'(lows), 32'd90);
        check("t6_final_status", o_status, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
